// File: rtl/video_timing_gen.sv
// Video timing generator for one pixel clock domain.
// Raster counters plus run/stop control that only stops at a frame boundary.
// hs/vs/de/clip are delayed PIXEL_DELAY cycles to line up with color_in, and
// each colour field is expanded to BPC bits by bit replication.
// Optional build macro: VIDEO_TIMING_GEN_TESTPAT_EN adds a testpat input that
// substitutes 8 vertical colour bars for color_in.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_STOPPED   | counters held at 0, idle values shifted into the delay line
// S_RUNNING   | counting, enable high
// S_DRAINING  | counting, enable low; stops after the last pixel of the frame
module video_timing_gen #(
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BP        = 220,
    parameter int V_ACTIVE    = 720,
    parameter int V_FP        = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 20,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int CLIP_W      = 1280,
    parameter int CLIP_H      = 512,
    parameter int PIXEL_DELAY = 2,
    parameter int BPP         = 3,
    parameter int BPC         = 8,
    parameter int COUNT_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
    input  logic                  testpat,
`endif
    input  logic [BPP-1:0]        color_in,
    output logic [COUNT_BITS-1:0] count_h,
    output logic [COUNT_BITS-1:0] count_v,
    output logic                  frame_start,
    output logic                  line_start,
    output logic                  running,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic [BPC-1:0]        vga_r,
    output logic [BPC-1:0]        vga_g,
    output logic [BPC-1:0]        vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FW      = BPP / 3;

    localparam logic [COUNT_BITS-1:0] H_LAST   = COUNT_BITS'(H_TOTAL - 1);
    localparam logic [COUNT_BITS-1:0] V_LAST   = COUNT_BITS'(V_TOTAL - 1);
    localparam logic [COUNT_BITS-1:0] H_ACT_C  = COUNT_BITS'(H_ACTIVE);
    localparam logic [COUNT_BITS-1:0] V_ACT_C  = COUNT_BITS'(V_ACTIVE);
    // Sync windows use inclusive last positions so they never exceed the counter range
    localparam logic [COUNT_BITS-1:0] HS_FIRST = COUNT_BITS'(H_ACTIVE + H_FP);
    localparam logic [COUNT_BITS-1:0] HS_LAST  = COUNT_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COUNT_BITS-1:0] VS_FIRST = COUNT_BITS'(V_ACTIVE + V_FP);
    localparam logic [COUNT_BITS-1:0] VS_LAST  = COUNT_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COUNT_BITS-1:0] CLIP_W_C = COUNT_BITS'(CLIP_W);
    localparam logic [COUNT_BITS-1:0] CLIP_H_C = COUNT_BITS'(CLIP_H);
    localparam logic [COUNT_BITS-1:0] ONE      = COUNT_BITS'(1);

    localparam logic HS_ON  = (HS_POL != 0);
    localparam logic HS_OFF = (HS_POL == 0);
    localparam logic VS_ON  = (VS_POL != 0);
    localparam logic VS_OFF = (VS_POL == 0);

    typedef enum logic [1:0] {
        S_STOPPED  = 2'd0,
        S_RUNNING  = 2'd1,
        S_DRAINING = 2'd2
    } state_t;

    // One entry of the output delay line
    typedef struct packed {
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
        logic [2:0] bar;
`endif
        logic       clip;
        logic       de;
        logic       vs;
        logic       hs;
    } stage_t;

    function automatic stage_t idle_stage();
        stage_t s;
        s    = '0;
        s.hs = HS_OFF;
        s.vs = VS_OFF;
        return s;
    endfunction

    // MSB-first replication of a colour field up to BPC bits
    function automatic logic [BPC-1:0] expand(input logic [FW-1:0] f);
        logic [BPC-1:0] x;
        x = '0;
        for (int i = 0; i < BPC; i++) begin
            x[BPC-1-i] = f[FW-1-(i % FW)];
        end
        return x;
    endfunction

    state_t                state;
    logic [COUNT_BITS-1:0] next_h;
    logic [COUNT_BITS-1:0] next_v;
    logic                  frame_end;
    stage_t                raw;
    stage_t                pipe [PIXEL_DELAY];
    stage_t                out_s;
    logic [BPC-1:0]        r_x;
    logic [BPC-1:0]        g_x;
    logic [BPC-1:0]        b_x;
    logic                  pixel_en;

`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
    localparam logic [COUNT_BITS+2:0] BAR_DIV = (COUNT_BITS+3)'(H_ACTIVE);
    localparam logic [COUNT_BITS+2:0] BAR_MAX = (COUNT_BITS+3)'(7);
    logic [COUNT_BITS+2:0] bar_full;
    logic [2:0]            bar_col;
    assign bar_full = {count_h, 3'b000} / BAR_DIV;
`endif

    // Next raster position, wrapping per line and per frame
    always_comb begin
        next_h    = (count_h == H_LAST) ? '0 : count_h + ONE;
        next_v    = count_v;
        if (count_h == H_LAST) begin
            next_v = (count_v == V_LAST) ? '0 : count_v + ONE;
        end
        frame_end = (count_h == H_LAST) && (count_v == V_LAST);
    end

    // Run/stop state machine with counters and aligned strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_STOPPED;
            count_h     <= '0;
            count_v     <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            running     <= 1'b0;
        end else begin
            case (state)
                S_STOPPED: begin
                    count_h <= '0;
                    count_v <= '0;
                    if (enable) begin
                        // first counted cycle sits at (0,0), which is both a frame and line start
                        state       <= S_RUNNING;
                        running     <= 1'b1;
                        frame_start <= 1'b1;
                        line_start  <= 1'b1;
                    end else begin
                        running     <= 1'b0;
                        frame_start <= 1'b0;
                        line_start  <= 1'b0;
                    end
                end
                S_RUNNING, S_DRAINING: begin
                    if (state == S_DRAINING && frame_end && !enable) begin
                        state       <= S_STOPPED;
                        count_h     <= '0;
                        count_v     <= '0;
                        running     <= 1'b0;
                        frame_start <= 1'b0;
                        line_start  <= 1'b0;
                    end else begin
                        state       <= enable ? S_RUNNING : S_DRAINING;
                        count_h     <= next_h;
                        count_v     <= next_v;
                        running     <= 1'b1;
                        frame_start <= (next_h == '0) && (next_v == '0);
                        line_start  <= (next_h == '0) && (next_v < V_ACT_C);
                    end
                end
                default: begin
                    state       <= S_STOPPED;
                    count_h     <= '0;
                    count_v     <= '0;
                    running     <= 1'b0;
                    frame_start <= 1'b0;
                    line_start  <= 1'b0;
                end
            endcase
        end
    end

    // Undelayed sync/enable/clip decode; idle values whenever not counting
    always_comb begin
        raw = idle_stage();
        if (running) begin
            raw.hs   = (count_h >= HS_FIRST && count_h <= HS_LAST) ? HS_ON : HS_OFF;
            raw.vs   = (count_v >= VS_FIRST && count_v <= VS_LAST) ? VS_ON : VS_OFF;
            raw.de   = (count_h < H_ACT_C) && (count_v < V_ACT_C);
            raw.clip = (count_h < CLIP_W_C) && (count_v < CLIP_H_C);
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
            raw.bar  = (bar_full > BAR_MAX) ? 3'd7 : bar_full[2:0];
`endif
        end
    end

    // Delay line matching the pixel source latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIXEL_DELAY; i++) begin
                pipe[i] <= idle_stage();
            end
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i < PIXEL_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_s  = pipe[PIXEL_DELAY-1];
    assign vga_hs = out_s.hs;
    assign vga_vs = out_s.vs;
    assign vga_de = out_s.de;

    // Colour expansion and blanking; color_in passes straight through
    always_comb begin
        r_x = expand(color_in[BPP-1 -: FW]);
        g_x = expand(color_in[2*FW-1 -: FW]);
        b_x = expand(color_in[FW-1:0]);
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
        bar_col = 3'd7 - out_s.bar;
        if (testpat) begin
            r_x = {BPC{bar_col[2]}};
            g_x = {BPC{bar_col[1]}};
            b_x = {BPC{bar_col[0]}};
        end
`endif
        pixel_en = out_s.de & out_s.clip;
        vga_r    = pixel_en ? r_x : '0;
        vga_g    = pixel_en ? g_x : '0;
        vga_b    = pixel_en ? b_x : '0;
    end

endmodule
